seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised, clocked successor of the 4-bit combinational arithmetic device: add/sub/mul/div
//  on W-bit unsigned operands with a 2W-bit result. Ready/valid handshake on both sides.
//  Multi-cycle iterative divider. Sits between an operand source and a result consumer.
// PARAMETERS
//  W      4   operand width (>=2); result width is 2*W
// PORTS
//  clk        in   1    system clock, all state on rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    operands/opcode valid
//  in_ready   out  1    block can accept operands this cycle
//  in1        in   W    operand A (dividend for div)
//  in2        in   W    operand B (divisor for div)
//  opcode     in   2    00 add, 01 sub, 10 mul, 11 div
//  out_valid  out  1    out_data valid
//  out_ready  in   1    consumer accepts out_data this cycle
//  out_data   out  2W   result
//  flags      out  3    {dz, neg, zero}; present only with SEQ_ALU_FLAGS_EN
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, out_data=0, flags=0, divider regs cleared; in_ready follows state.
//  - FSM: IDLE -> (accept, op!=div) -> IDLE with result registered; IDLE -> (accept, div) -> DIV;
//    DIV -> W iterations -> DONE; DONE -> IDLE in the cycle the result is loaded into the output register.
//  - in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
//  - Latency: add/sub/mul accepted at edge N -> out_valid=1 after edge N+1 (1 cycle).
//    div accepted at edge N -> out_valid=1 after edge N+W+1.
//  - Output register holds out_data/flags stable while out_valid && !out_ready; cleared valid on
//    out_ready unless a new result loads in the same cycle (back-to-back 1/cycle for add/sub/mul).
//  - add: zero-extend operands, out = in1+in2 (max 2^(W+1)-2, never overflows 2W).
//  - sub: out = in1-in2 in 2W-bit two's complement (sign-extended); neg=1 when in1<in2.
//  - mul: unsigned full product, 2W bits.
//  - div: restoring, one quotient bit per cycle MSB-first; out = {remainder[W-1:0], quotient[W-1:0]}.
//  - div by zero: quotient=all ones, remainder=in1, dz=1; still takes W+1 cycles (fixed latency).
//  - zero=1 when out_data==0; flags update only when a new result is loaded.
//  - in_valid while busy (DIV/DONE or output stalled): ignored, in_ready=0; source must hold.
//  - Inputs are captured at accept; later changes to in1/in2/opcode do not affect an op in flight.
//  - rst_n low mid-division or mid-stall: immediate abort, all state to reset values, result lost.
// CONFIGURATION
//  SEQ_ALU_FLAGS_EN defined: flags port and flag registers exist as above.
//  Not defined: flags port absent, no flag logic; data results (incl. div-by-zero value) identical.
// STRUCTURE
//  seq_alu_pkg: opcode enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV), FSM state enum (IDLE, DIV, DONE),
//    flag bit index constants (FLAG_ZERO=0, FLAG_NEG=1, FLAG_DZ=2).
//  Sub-module seq_alu_divider #(W): start/busy/done, dividend/divisor in, quotient/remainder out,
//    W-cycle restoring iteration, own async reset. Top holds FSM, add/sub/mul path, output register.
// TESTING (W=4)
//  1. 2+3 op=00, out_ready=1 -> out_valid one cycle after accept, out_data=8'h05, zero=0.
//  2. 5-3 -> 8'h02 neg=0; 3-5 -> 8'hFE neg=1; 3-3 -> 8'h00 zero=1.
//  3. 2*3 -> 8'h06; 15*15 -> 8'hE1; back-to-back 3 mul with in_valid=1 -> 3 results, 1/cycle.
//  4. 6/3 -> out_data=8'h02 after W+1=5 cycles, in_ready=0 throughout; 15/4 -> 8'h33; 7/0 -> 8'h7F dz=1.
//  5. Backpressure: out_ready=0 for 3 cycles after result -> out_data held, in_ready=0; release -> drains.
//  6. Assert rst_n low 2 cycles into a division -> out_valid=0, out_data=0, in_ready=1 after release;
//     subsequent 2+3 -> 8'h05. Run suite with and without SEQ_ALU_FLAGS_EN, and at W=8.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU.
// Opcodes, FSM states and flag bit positions.
package seq_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DIV  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_DZ   = 2;

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu.
// flags exists only when SEQ_ALU_FLAGS_EN is defined.
interface seq_alu_if #(
  parameter int W = 4
);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in1;
  logic [W-1:0]   in2;
  logic [1:0]     opcode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_data;
`ifdef SEQ_ALU_FLAGS_EN
  logic [2:0]     flags;
`endif

  modport master (
    output in_valid, in1, in2, opcode,
    output out_ready,
`ifdef SEQ_ALU_FLAGS_EN
    input  flags,
`endif
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in1, in2, opcode,
    input  out_ready,
`ifdef SEQ_ALU_FLAGS_EN
    output flags,
`endif
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/seq_alu_divider.sv
// Restoring divider, one quotient bit per cycle, MSB first.
// First iteration runs on the start edge from the raw operands.
module seq_alu_divider #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);

  logic [CW-1:0] count;
  logic          run;
  logic [W-1:0]  quo;
  logic [W-1:0]  rem;
  logic [W-1:0]  dsr;
  logic [W-1:0]  r0;
  logic [W-1:0]  q0;
  logic [W-1:0]  d0;
  logic [W:0]    sh;
  logic [W-1:0]  diff;
  logic          fits;

  // One shift/compare/subtract step; a zero divisor always fits,
  // which yields all-ones quotient and the dividend as remainder.
  always_comb begin
    r0   = start ? '0 : rem;
    q0   = start ? dividend : quo;
    d0   = start ? divisor : dsr;
    sh   = {r0, q0[W-1]};
    fits = sh >= {1'b0, d0};
    diff = sh[W-1:0] - d0;
  end

  assign done      = run && (count == CW'(W-1));
  assign busy      = run;
  assign quotient  = quo;
  assign remainder = rem;

  // Iteration state: W steps starting at the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      count <= '0;
      quo   <= '0;
      rem   <= '0;
      dsr   <= '0;
    end else if (start || run) begin
      rem   <= fits ? diff : sh[W-1:0];
      quo   <= {q0[W-2:0], fits};
      dsr   <= d0;
      count <= start ? CW'(1) : count + CW'(1);
      run   <= start ? 1'b1 : !done;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Clocked add/sub/mul/div with ready/valid on both sides.
// Build option: SEQ_ALU_FLAGS_EN adds the {dz, neg, zero} flags.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);

  state_e         state;
  state_e         state_nx;
  op_e            op;
  logic           accept;
  logic           start;
  logic           load;
  logic [2*W-1:0] a;
  logic [2*W-1:0] b;
  logic [2*W-1:0] alu_res;
  logic [2*W-1:0] res;
  logic           div_busy;
  logic           div_done;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;

  assign op = op_e'(bus.opcode);

  seq_alu_divider #(.W(W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (bus.in1),
    .divisor   (bus.in2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: divide runs W steps then one load cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)    state_nx = DIV;
      DIV:     if (div_done) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake and load strobes derived from state.
  always_comb begin
    bus.in_ready = (state == IDLE) && !div_busy &&
                   (!bus.out_valid || bus.out_ready);
    accept = bus.in_valid && bus.in_ready;
    start  = accept && (op == OP_DIV);
    load   = (accept && (op != OP_DIV)) || (state == DONE);
  end

  // Single-cycle arithmetic on zero-extended operands.
  always_comb begin
    a = {{W{1'b0}}, bus.in1};
    b = {{W{1'b0}}, bus.in2};
    unique case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_MUL:  alu_res = a * b;
      default: alu_res = '0;
    endcase
    res = (state == DONE) ? {rem, quo} : alu_res;
  end

  // Output register: holds under backpressure, reloads back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= res;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef SEQ_ALU_FLAGS_EN
  logic dz_pend;

  // Remember a zero divisor for the duration of the divide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     dz_pend <= 1'b0;
    else if (start) dz_pend <= (bus.in2 == '0);
  end

  // Flags change only alongside a new result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.flags <= '0;
    end else if (load) begin
      bus.flags[FLAG_ZERO] <= (res == '0);
      bus.flags[FLAG_NEG]  <= (state != DONE) &&
                              (op == OP_SUB) &&
                              (bus.in1 < bus.in2);
      bus.flags[FLAG_DZ]   <= (state == DONE) && dz_pend;
    end
  end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu.
// Flag checks compile in only with SEQ_ALU_FLAGS_EN.
module tb_seq_alu;

  parameter int W = 4;
  localparam int RW = 2 * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  seq_alu_if #(.W(W)) bus();

  seq_alu #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] model(
    input longint a, input longint b, input int op);
    longint r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      default:
        if (b == 0) r = (a << W) | ((longint'(1) << W) - 1);
        else        r = ((a % b) << W) | (a / b);
    endcase
    return RW'(r);
  endfunction

  function automatic logic [2:0] fmodel(
    input longint a, input longint b, input int op,
    input logic [RW-1:0] r);
    return {op == 3 && b == 0, op == 1 && a < b, r == '0};
  endfunction

  function automatic logic [2:0] get_flags();
`ifdef SEQ_ALU_FLAGS_EN
    return bus.flags;
`else
    return 3'b000;
`endif
  endfunction

  task automatic run_op(
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [1:0]    op,
    output logic [RW-1:0] data,
    output logic [2:0]    fl,
    output int            lat,
    output int            rdy_busy);
    bus.in1 = a;
    bus.in2 = b;
    bus.opcode = op;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4 * W + 8 && !bus.in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in1 = W'($urandom);
    bus.in2 = W'($urandom);
    bus.opcode = 2'($urandom);
    lat = 1;
    rdy_busy = 0;
    while (!bus.out_valid && lat < W + 8) begin
      if (bus.in_ready) rdy_busy++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    data = bus.out_data;
    fl = get_flags();
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.opcode = 2'b00;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      failures++;
      $display("FAIL reset_out valid=%b data=%h want 0/0",
               bus.out_valid, bus.out_data);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b want 1", bus.in_ready);
    end
`ifdef SEQ_ALU_FLAGS_EN
    checks++;
    if (bus.flags !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b want 000", bus.flags);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [W-1:0]  av [9] = '{2, 5, 3, 3, 2, 15, 6, 15, 7};
    logic [W-1:0]  bv [9] = '{3, 3, 5, 3, 3, 15, 3, 4, 0};
    int            ov [9] = '{0, 1, 1, 1, 2, 2, 3, 3, 3};
    logic [RW-1:0] d;
    logic [RW-1:0] e;
    logic [2:0]    fl;
    int            lat;
    int            rb;
    int            el;
    for (int i = 0; i < 9; i++) begin
      run_op(av[i], bv[i], 2'(ov[i]), d, fl, lat, rb);
      e = model(longint'(av[i]), longint'(bv[i]), ov[i]);
      el = (ov[i] == 3) ? W + 1 : 1;
      checks++;
      if (d !== e) begin
        failures++;
        $display("FAIL dir_data i=%0d got=%h want=%h", i, d, e);
      end
      checks++;
      if (lat != el || rb != 0) begin
        failures++;
        $display("FAIL dir_lat i=%0d got=%0d rdy=%0d want=%0d",
                 i, lat, rb, el);
      end
`ifdef SEQ_ALU_FLAGS_EN
      checks++;
      if (fl !== fmodel(longint'(av[i]), longint'(bv[i]), ov[i], e)) begin
        failures++;
        $display("FAIL dir_flags i=%0d got=%b", i, fl);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    int            op;
    logic [RW-1:0] d;
    logic [RW-1:0] e;
    logic [2:0]    fl;
    int            lat;
    int            rb;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      op = int'($urandom_range(0, 3));
      if (op == 3 && $urandom_range(0, 4) == 0) b = '0;
      run_op(a, b, 2'(op), d, fl, lat, rb);
      e = model(longint'(a), longint'(b), op);
      checks++;
      if (d !== e || lat != ((op == 3) ? W + 1 : 1)) begin
        failures++;
        $display("FAIL rand op=%0d a=%h b=%h got=%h lat=%0d want=%h",
                 op, a, b, d, lat, e);
      end
`ifdef SEQ_ALU_FLAGS_EN
      checks++;
      if (fl !== fmodel(longint'(a), longint'(b), op, e)) begin
        failures++;
        $display("FAIL rand_flags op=%0d got=%b", op, fl);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]  a [3];
    logic [W-1:0]  b [3];
    logic [RW-1:0] e;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a[i] = W'($urandom);
      b[i] = W'($urandom);
    end
    bus.in_valid = 1'b1;
    bus.opcode = 2'b10;
    for (int i = 0; i < 3; i++) begin
      bus.in1 = a[i];
      bus.in2 = b[i];
      @(posedge clk);
      #1;
      e = model(longint'(a[i]), longint'(b[i]), 2);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
        failures++;
        $display("FAIL b2b i=%0d valid=%b got=%h want=%h",
                 i, bus.out_valid, bus.out_data, e);
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] e;
    e = model(4, 7, 0);
    bus.out_ready = 1'b0;
    bus.in1 = W'(4);
    bus.in2 = W'(7);
    bus.opcode = 2'b00;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in1 = W'(1);
    bus.in2 = W'(1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e ||
          bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall i=%0d v=%b rdy=%b got=%h want=%h",
                 i, bus.out_valid, bus.in_ready, bus.out_data, e);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release v=%b rdy=%b want 0/1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_div();
    logic [RW-1:0] d;
    logic [2:0]    fl;
    int            lat;
    int            rb;
    int            seen;
    bus.out_ready = 1'b1;
    bus.in1 = W'(7);
    bus.in2 = W'(2);
    bus.opcode = 2'b11;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
        bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort v=%b data=%h rdy=%b want 0/0/1",
               bus.out_valid, bus.out_data, bus.in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_lost got=%0d valid cycles want 0", seen);
    end
    run_op(W'(2), W'(3), 2'b00, d, fl, lat, rb);
    checks++;
    if (d !== model(2, 3, 0) || lat != 1) begin
      failures++;
      $display("FAIL post_reset got=%h lat=%0d want=%h",
               d, lat, model(2, 3, 0));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
